// File: rtl/seven_seg_scheduler_pkg.sv
// Shared types and constants for the seven-segment display scheduler.
// Holds the FSM encoding, the source-id codes and the round-robin pick helper.
package seven_seg_scheduler_pkg;

  typedef enum logic [1:0] {
    SHOW_PC  = 2'd0,
    SHOW_REQ = 2'd1,
    GAP      = 2'd2
  } sched_state_e;

  localparam logic [1:0] SRC_PC  = 2'd0;
  localparam logic [1:0] SRC_A   = 2'd1;
  localparam logic [1:0] SRC_B   = 2'd2;
  localparam logic [1:0] SRC_GAP = 2'd3;

  // A wins when it is alone, or on a tie when B was granted last.
  function automatic logic pick_a(input logic req_a, input logic req_b, input logic last_b);
    return req_a && (!req_b || last_b);
  endfunction

endpackage

// File: rtl/seven_seg_scheduler_refresh_tick_gen.sv
// Prescaler plus 2-bit digit counter: emits the registered digit-step pulse
// and the end-of-frame tick (step on the last digit); paused by freeze.
module refresh_tick_gen
  import seven_seg_scheduler_pkg::*;
#(
  parameter int PRESCALE = 50000,
  parameter int CNTW     = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic freeze_i,
  output logic stepen_o,
  output logic frametick_o
);

  localparam logic [CNTW-1:0] PRESC_LAST = CNTW'(PRESCALE - 1);

  logic [CNTW-1:0] presc_q, presc_d;
  logic            step_q, step_d;
  logic [1:0]      digit_q, digit_d;

  // Next-state for prescaler, step pulse and digit position.
  always_comb begin
    presc_d = presc_q;
    step_d  = 1'b0;
    digit_d = digit_q;
    if (step_q) begin
      digit_d = digit_q + 2'd1;
    end else begin
      digit_d = digit_q;
    end
    if (!freeze_i) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        step_d  = 1'b1;
      end else begin
        presc_d = presc_q + CNTW'(1);
        step_d  = 1'b0;
      end
    end else begin
      presc_d = presc_q;
      step_d  = 1'b0;
    end
  end

  // Counter and pulse registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q <= '0;
      step_q  <= 1'b0;
      digit_q <= 2'd0;
    end else begin
      presc_q <= presc_d;
      step_q  <= step_d;
      digit_q <= digit_d;
    end
  end

  assign stepen_o    = step_q;
  assign frametick_o = step_q && (digit_q == 2'd3);

endmodule

// File: rtl/seven_seg_scheduler.sv
// Display source scheduler: shows the live PC by default and lends the display
// to requester A or B for HOLD_FRAMES frames, followed by one blank gap frame.
module seven_seg_scheduler
  import seven_seg_scheduler_pkg::*;
#(
  parameter int PRESCALE    = 50000,
  parameter int HOLD_FRAMES = 256,
  parameter int CNTW        = 16,
  parameter int HOLDW       = 8
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        freeze,
  input  logic [15:0] pcval,
  input  logic        reqa,
  input  logic [15:0] dataa,
  input  logic        reqb,
  input  logic [15:0] datab,
  output logic        gnta,
  output logic        gntb,
  output logic        stepen,
  output logic [15:0] dispval,
  output logic        dispblank,
  output logic [1:0]  srcid,
  output logic        busy
);

  localparam logic [HOLDW-1:0] HOLD_LAST = HOLDW'(HOLD_FRAMES - 1);

  sched_state_e     state_q, state_d;
  logic [HOLDW-1:0] hold_q, hold_d;
  logic             last_b_q, last_b_d;
  logic [15:0]      disp_q, disp_d;
  logic             gnta_q, gnta_d, gntb_q, gntb_d;
  logic             blank_q, blank_d, busy_q, busy_d;
  logic [1:0]       srcid_q, srcid_d;
  logic             frametick_s, grant_s, win_a_s;

  refresh_tick_gen #(
    .PRESCALE(PRESCALE),
    .CNTW    (CNTW)
  ) u_tick (
    .clk_i      (clock),
    .rst_ni     (resetn),
    .freeze_i   (freeze),
    .stepen_o   (stepen),
    .frametick_o(frametick_s)
  );

  // Scheduler FSM, arbiter and next values of the registered outputs.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    last_b_d = last_b_q;
    disp_d   = disp_q;
    gnta_d   = 1'b0;
    gntb_d   = 1'b0;
    grant_s  = 1'b0;
    win_a_s  = pick_a(reqa, reqb, last_b_q);
    case (state_q)
      SHOW_PC: begin
        disp_d  = pcval;
        grant_s = frametick_s && (reqa || reqb);
      end
      SHOW_REQ: begin
        if (frametick_s) begin
          if (hold_q == HOLD_LAST) begin
            state_d = GAP;
          end else begin
            hold_d = hold_q + HOLDW'(1);
          end
        end else begin
          hold_d = hold_q;
        end
      end
      GAP: begin
        if (frametick_s) begin
          if (reqa || reqb) begin
            grant_s = 1'b1;
          end else begin
            state_d = SHOW_PC;
          end
        end else begin
          state_d = GAP;
        end
      end
      default: state_d = SHOW_PC;
    endcase
    // A grant restarts the hold and latches the winner's data with its pulse.
    if (grant_s) begin
      state_d  = SHOW_REQ;
      hold_d   = '0;
      last_b_d = !win_a_s;
      disp_d   = win_a_s ? dataa : datab;
      gnta_d   = win_a_s;
      gntb_d   = !win_a_s;
    end else begin
      last_b_d = last_b_q;
    end
    case (state_d)
      SHOW_PC:  srcid_d = SRC_PC;
      SHOW_REQ: srcid_d = grant_s ? (win_a_s ? SRC_A : SRC_B) : srcid_q;
      GAP:      srcid_d = SRC_GAP;
      default:  srcid_d = SRC_PC;
    endcase
    busy_d  = (state_d != SHOW_PC);
    blank_d = (state_d == GAP);
  end

  // State and output registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= SHOW_PC;
      hold_q   <= '0;
      last_b_q <= 1'b1;
      disp_q   <= 16'd0;
      gnta_q   <= 1'b0;
      gntb_q   <= 1'b0;
      blank_q  <= 1'b0;
      busy_q   <= 1'b0;
      srcid_q  <= SRC_PC;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      last_b_q <= last_b_d;
      disp_q   <= disp_d;
      gnta_q   <= gnta_d;
      gntb_q   <= gntb_d;
      blank_q  <= blank_d;
      busy_q   <= busy_d;
      srcid_q  <= srcid_d;
    end
  end

  assign gnta      = gnta_q;
  assign gntb      = gntb_q;
  assign dispval   = disp_q;
  assign dispblank = blank_q;
  assign srcid     = srcid_q;
  assign busy      = busy_q;

endmodule
